// File: rtl/bus_divider.sv
// Multi-cycle restoring divider fed from the datapath bus; quotient -> Z low, remainder -> Z high.
// Define DIV_SIGNED_EN for two's-complement signed division; the default build divides unsigned.
module bus_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             y_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] z_low,
  output logic [WIDTH-1:0] z_high
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] zl_q, zl_d;
  logic [WIDTH-1:0] zh_q, zh_d;

  logic [WIDTH-1:0] div_mag;
  logic [WIDTH:0]   rem_shift;
  logic             take;

`ifdef DIV_SIGNED_EN
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             y_neg_q, y_neg_d;
  logic             d_neg_q, d_neg_d;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign div_mag = dmag_q;
`else
  assign div_mag = d_q;
`endif

  // Trial subtraction is one bit wider than the operands so the shifted-out bit is never lost.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign take      = (rem_shift >= {1'b0, div_mag});

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    d_d     = d_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dz_d    = dz_q;
    zl_d    = zl_q;
    zh_d    = zh_q;
`ifdef DIV_SIGNED_EN
    dmag_d  = dmag_q;
    y_neg_d = y_neg_q;
    d_neg_d = d_neg_q;
`endif

    case (state_q)
      IDLE: begin
        if (y_in) begin
          y_d = bus_in;
        end
        // Start reads the Y held before this edge, even when y_in reloads it simultaneously.
        if (start) begin
          d_d     = bus_in;
          dz_d    = 1'b0;
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef DIV_SIGNED_EN
          quo_d   = mag(y_q);
          dmag_d  = mag(bus_in);
          y_neg_d = y_q[WIDTH-1];
          d_neg_d = bus_in[WIDTH-1];
`else
          quo_d   = y_q;
`endif
        end
      end

      RUN: begin
        rem_d = take ? WIDTH'(rem_shift - {1'b0, div_mag}) : rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], take};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
        end
      end

      FIX: begin
        done_d  = 1'b1;
        state_d = DONE;
        if (d_q == '0) begin
          zl_d = '1;
          zh_d = y_q;
          dz_d = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
          // Truncating division: remainder follows the dividend's sign.
          zl_d = (y_neg_q ^ d_neg_q) ? -quo_q : quo_q;
          zh_d = y_neg_q ? -rem_q : rem_q;
`else
          zl_d = quo_q;
          zh_d = rem_q;
`endif
        end
      end

      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      d_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      zl_q    <= '0;
      zh_q    <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      zl_q    <= zl_d;
      zh_q    <= zh_d;
    end
  end

`ifdef DIV_SIGNED_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dmag_q  <= '0;
      y_neg_q <= 1'b0;
      d_neg_q <= 1'b0;
    end else begin
      dmag_q  <= dmag_d;
      y_neg_q <= y_neg_d;
      d_neg_q <= d_neg_d;
    end
  end
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign z_low       = zl_q;
  assign z_high      = zh_q;

endmodule

// File: tb/tb_bus_divider.sv
// Scoreboard bench for bus_divider: stimulus pushes model results, a monitor checks each done pulse.
module tb_bus_divider;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [31:0] bus_in = '0;
  logic        y_in = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] z_low, z_high;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] zl;
    logic [31:0] zh;
    logic        dz;
    int          e0;
    logic [31:0] y;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_y = '0;

  bus_divider #(.WIDTH(32)) dut (
    .clk(clk), .clr_n(clr_n), .bus_in(bus_in), .y_in(y_in), .start(start),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .z_low(z_low), .z_high(z_high)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  task automatic push_exp(input logic [31:0] y, input logic [31:0] d, input int e0);
    exp_t   e;
    longint ys, ds, q, r;
    e.y = y; e.d = d; e.e0 = e0;
    if (d == 0) begin
      e.zl = 32'hFFFF_FFFF; e.zh = y; e.dz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      ys = longint'(signed'(y));
      ds = longint'(signed'(d));
`else
      ys = longint'({32'd0, y});
      ds = longint'({32'd0, d});
`endif
      q = ys / ds;
      r = ys % ds;
      e.zl = q[31:0]; e.zh = r[31:0]; e.dz = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (clr_n && done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending division");
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn %h / %h -> z_low=%h z_high=%h dz=%0d", e.y, e.d, z_low, z_high, div_by_zero);
        check("z_low", z_low, e.zl);
        check("z_high", z_high, e.zh);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        check("latency", 32'(cyc - e.e0), 32'd33);
      end
    end
  end

  // Called at a negedge; returns at a negedge.
  task automatic load_y(input logic [31:0] v);
    bus_in = v; y_in = 1'b1;
    @(negedge clk);
    y_in = 1'b0;
    model_y = v;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    checks++; errors++;
    $display("FAIL idle_timeout: got busy=1 expected busy=0 within 100 cycles");
  endtask

  task automatic go(input logic [31:0] d, input bit also_y, input int poke);
    bus_in = d; start = 1'b1;
    y_in = also_y;
    push_exp(model_y, d, cyc + 1);
    if (also_y) model_y = d;
    @(negedge clk);
    start = 1'b0; y_in = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    if (poke > 0) begin
      repeat (poke - 1) @(negedge clk);
      bus_in = '0; start = 1'b1; y_in = 1'b1;
      @(negedge clk);
      start = 1'b0; y_in = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] ry, rd;
    int          sel;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz", {31'd0, div_by_zero}, 32'd0);
    check("rst_z_low", z_low, 32'd0);
    check("rst_z_high", z_high, 32'd0);
    clr_n = 1'b1;
    @(negedge clk);

    load_y(32'd100);        go(32'd7, 1'b0, 0);
    load_y(32'hFFFF_FF9C);  go(32'd7, 1'b0, 0);
    load_y(32'd5);          go(32'd0, 1'b0, 0);
    load_y(32'd9);          go(32'd3, 1'b0, 0);
    load_y(32'h8000_0000);  go(32'hFFFF_FFFF, 1'b0, 0);

    // Pokes mid-run must be ignored; Y must still hold 100 afterwards.
    load_y(32'd100);        go(32'd7, 1'b0, 10);
    go(32'd7, 1'b0, 0);

    // Simultaneous y_in/start: divide old Y, then Y holds the new bus value.
    load_y(32'd50);         go(32'd9, 1'b1, 0);
    go(32'd3, 1'b0, 0);

    // Asynchronous abort mid-run.
    load_y(32'd100);
    bus_in = 32'd7; start = 1'b1;
    push_exp(model_y, 32'd7, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_z_low", z_low, 32'd0);
    check("abort_z_high", z_high, 32'd0);
    sb.delete();
    model_y = '0;
    @(negedge clk);
    clr_n = 1'b1;
    repeat (40) @(negedge clk);
    load_y(32'd100);        go(32'd7, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      ry  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      rd = 32'd0;
      else if (sel < 4)  rd = 32'($urandom_range(1, 15));
      else if (sel == 4) rd = 32'hFFFF_FFFF;
      else               rd = $urandom;
      if (sel == 5) ry = ry >> $urandom_range(0, 31);
      load_y(ry);
      go(rd, 1'b0, 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
